// File: rtl/fir_ctrl_pkg.sv
// Shared control definitions for the FIR filter: sequencer states and
// default filter dimensions used by both the sequencer and the datapath.
package fir_ctrl_pkg;

    localparam int FIR_TAPS = 4;
    localparam int FIR_DW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MAC,
        ST_DRAIN,
        ST_LOAD
    } fir_state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Board-input / datapath-control bundle of the FIR MAC sequencer.
// The slave side is the sequencer; the master side drives go/in and
// observes the datapath strobes.
interface fir_mac_sequencer_if
    import fir_ctrl_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = FIR_DW
) ();

    logic          go;
    logic [DW-1:0] in;
    logic [DW-1:0] sample;
    logic          shift_en;
    logic [AW-1:0] tap_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          y_load;
    logic          busy;
    logic          done;
    logic          overrun;

    modport master (
        output go, in,
        input  sample, shift_en, tap_addr, mac_clr, mac_en,
               y_load, busy, done, overrun
    );

    modport slave (
        input  go, in,
        output sample, shift_en, tap_addr, mac_clr, mac_en,
               y_load, busy, done, overrun
    );

endinterface

// File: rtl/go_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a third
// flop that turns each synchronised rising edge into a one-cycle pulse.
module go_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain plus delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer that time-shares one MAC datapath across all FIR taps:
// shift the captured sample in, run one MAC per tap, drain the multiplier
// register, then load the result. Go requests during a computation are
// dropped and flagged in the sticky overrun bit.
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = FIR_TAPS,
    parameter int AW   = 2,
    parameter int DW   = FIR_DW
) (
    input logic                 clk,
    input logic                 rst,
    fir_mac_sequencer_if.slave  bus
);

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    fir_state_t    r_state;
    logic [DW-1:0] r_sample;
    logic [AW-1:0] r_tap;
    logic          r_shift_en;
    logic          r_mac_clr;
    logic          r_mac_en;
    logic          r_y_load;
    logic          r_busy;
    logic          r_done;
    logic          r_overrun;
    logic          w_go_pulse;

    go_sync_edge u_go_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.go),
        .o_pulse (w_go_pulse)
    );

    // FSM, tap counter and registered strobes; each output is set to the
    // value it must hold in the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_sample   <= '0;
            r_tap      <= '0;
            r_shift_en <= 1'b0;
            r_mac_clr  <= 1'b0;
            r_mac_en   <= 1'b0;
            r_y_load   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_go_pulse && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_tap <= '0;
                    if (w_go_pulse) begin
                        r_state    <= ST_SHIFT;
                        r_sample   <= bus.in;
                        r_overrun  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift_en <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_state    <= ST_MAC;
                    r_shift_en <= 1'b0;
                    r_tap      <= '0;
                    r_mac_en   <= 1'b1;
                    r_mac_clr  <= 1'b1;
                end
                ST_MAC: begin
                    r_mac_clr <= 1'b0;
                    if (r_tap == LAST_TAP) begin
                        r_state  <= ST_DRAIN;
                        r_mac_en <= 1'b0;
                        r_tap    <= '0;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state  <= ST_LOAD;
                    r_y_load <= 1'b1;
                    r_done   <= 1'b1;
                end
                ST_LOAD: begin
                    r_state  <= ST_IDLE;
                    r_y_load <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sample   = r_sample;
    assign bus.shift_en = r_shift_en;
    assign bus.tap_addr = r_tap;
    assign bus.mac_clr  = r_mac_clr;
    assign bus.mac_en   = r_mac_en;
    assign bus.y_load   = r_y_load;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with TAPS=4.
// Cycle index i below counts rising edges from edge k (first edge sampling go=1).
module tb_fir_mac_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fir_mac_sequencer_if #(.AW(2), .DW(8)) bus ();

    fir_mac_sequencer #(.TAPS(4), .AW(2), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, shift_en, mac_en, mac_clr, y_load, done, tap_addr}
    function automatic logic [7:0] outs();
        return {bus.busy, bus.shift_en, bus.mac_en, bus.mac_clr,
                bus.y_load, bus.done, bus.tap_addr};
    endfunction

    task automatic test_reset();
        rst = 1'b0; bus.go = 1'b0; bus.in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({outs(), bus.overrun, bus.sample} !== 17'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", {outs(), bus.overrun, bus.sample});
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({outs(), bus.overrun, bus.sample} !== 17'h0) begin
                errors++;
                $display("FAIL idle_quiet[%0d]: got %h expected 0", i, {outs(), bus.overrun, bus.sample});
            end
        end
    endtask

    task automatic run_seq(input logic [7:0] val);
        logic [7:0] exp;
        int busy_cnt;
        int done_at;
        busy_cnt = 0; done_at = -1;
        @(negedge clk); bus.in = val; bus.go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) bus.go = 1'b0;
            exp = {(i >= 2 && i <= 8), (i == 2), (i >= 3 && i <= 6), (i == 3),
                   (i == 8), (i == 8), ((i >= 3 && i <= 6) ? 2'(i - 3) : 2'd0)};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL seq_outs[%0d]: got %b expected %b", i, outs(), exp);
            end
            if (i == 2) begin
                checks++;
                if (bus.sample !== val || bus.overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_capture: sample=%h ovr=%b expected %h/0", bus.sample, bus.overrun, val);
                end
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = i;
        end
        checks++;
        if (busy_cnt != 7 || done_at != 8) begin
            errors++;
            $display("FAIL seq_timing: busy=%0d done_at=%0d expected 7/8", busy_cnt, done_at);
        end
    endtask

    task automatic test_sequence();
        run_seq(8'h2A);
    endtask

    task automatic test_hold();
        int dones;
        logic ovr_seen;
        dones = 0; ovr_seen = 1'b0;
        @(negedge clk); bus.in = 8'h5A; bus.go = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
            if (bus.overrun) ovr_seen = 1'b1;
        end
        bus.go = 1'b0;
        repeat (4) @(posedge clk);
        checks++;
        if (dones != 1 || ovr_seen !== 1'b0) begin
            errors++;
            $display("FAIL hold_single: dones=%0d ovr=%b expected 1/0", dones, ovr_seen);
        end
    endtask

    task automatic test_overrun();
        int dones;
        dones = 0;
        @(negedge clk); bus.in = 8'h11; bus.go = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 2) bus.go = 1'b0;
            if (i == 3) bus.go = 1'b1;
            if (i == 6) bus.go = 1'b0;
            if (bus.done) dones++;
            if (i == 5 || i == 6) begin
                checks++;
                if (bus.overrun !== (i == 6)) begin
                    errors++;
                    $display("FAIL ovr_set[%0d]: got %b expected %b", i, bus.overrun, (i == 6));
                end
            end
        end
        checks++;
        if (dones != 1 || bus.overrun !== 1'b1 || bus.sample !== 8'h11) begin
            errors++;
            $display("FAIL ovr_sticky: dones=%0d ovr=%b sample=%h expected 1/1/11", dones, bus.overrun, bus.sample);
        end
        @(negedge clk); bus.in = 8'h55; bus.go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                checks++;
                if (bus.overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_before_capture: got %b expected 1", bus.overrun);
                end
            end
            if (i == 2) begin
                bus.go = 1'b0;
                checks++;
                if (bus.overrun !== 1'b0 || bus.sample !== 8'h55) begin
                    errors++;
                    $display("FAIL ovr_clear: ovr=%b sample=%h expected 0/55", bus.overrun, bus.sample);
                end
            end
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_load_drop();
        int dones;
        dones = 0;
        @(negedge clk); bus.in = 8'h77; bus.go = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 2) bus.go = 1'b0;
            if (i == 6) bus.go = 1'b1;
            if (i == 9) bus.go = 1'b0;
            if (bus.done) dones++;
            if (i == 8 || i == 9) begin
                checks++;
                if (bus.overrun !== (i == 9)) begin
                    errors++;
                    $display("FAIL load_drop_ovr[%0d]: got %b expected %b", i, bus.overrun, (i == 9));
                end
            end
            if (i == 12) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.shift_en !== 1'b0) begin
                    errors++;
                    $display("FAIL load_drop_idle: busy=%b shift=%b expected 0/0", bus.busy, bus.shift_en);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL load_drop_dones: got %0d expected 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); bus.in = 8'h3C; bus.go = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) bus.go = 1'b0;
        end
        checks++;
        if (bus.mac_en !== 1'b1 || bus.tap_addr !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre: mac_en=%b tap=%0d expected 1/2", bus.mac_en, bus.tap_addr);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({outs(), bus.overrun, bus.sample} !== 17'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", {outs(), bus.overrun, bus.sample});
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        run_seq(8'hC3);
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #2 bus.go = 1'b1;
        #2 bus.go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (outs() !== 8'h0) begin
                errors++;
                $display("FAIL glitch[%0d]: got %b expected 0", i, outs());
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_sequence();
        test_hold();
        test_overrun();
        test_load_drop();
        test_reset_mid();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
